icache_downstream_req_arb: RTL and testbench
============================================

// Module: icache_downstream_req_arb
// PURPOSE
//   Arbitrates downstream refill requests from all MSHR entries onto the single downstream request channel.
//   - Sits directly downstream of the MSHR entry buffers.
//   - Each entry in DOWNSTREAM_REQ state raises txreq_vld.
//   - Grants one entry per cycle, round-robin; pulses rdy + release_en together to the winner; registers its payload into a one-deep output stage.
//   - Bounds in-flight refills with a credit counter returned on linefill completion.
// PARAMETERS
//   ENTRY_NUM   8   number of MSHR entries (= MSHR_ENTRY_NUM)
//   PLD_W       42  request payload width {addr[31:0], txnid[4:0], opcode[4:0]}
//   CREDIT_NUM  4   max downstream refills in flight
//   ID_W        3   entry id width, $clog2(ENTRY_NUM)
// PORTS
//   clk              in   1                clock
//   rst_n            in   1                reset, asynchronous, active-low
//   ent_txreq_vld    in   ENTRY_NUM        per-entry request valid
//   ent_txreq_pld    in   ENTRY_NUM*PLD_W  per-entry payload; entry i at [i*PLD_W +: PLD_W]
//   ent_txreq_rdy    out  ENTRY_NUM        one-hot grant (accept) to entry
//   ent_release_en   out  ENTRY_NUM        one-hot release; identical to ent_txreq_rdy
//   ds_req_vld       out  1                downstream request valid
//   ds_req_rdy       in   1                downstream ready
//   ds_req_pld       out  PLD_W            downstream payload
//   ds_req_entry_id  out  ID_W             index of originating entry
//   ds_fill_done     in   1                one refill completed; returns one credit
//   credit_cnt       out  $clog2(CREDIT_NUM+1)  refills in flight
//   credit_err       out  1                sticky: fill_done seen with credit_cnt==0
// BEHAVIOUR
//   Reset: all outputs 0, rr_ptr=0, output stage empty, credit_cnt=0, credit_err=0.
//   slot_free = ~ds_req_vld | ds_req_rdy (bubble-free; accept while draining).
//   can_grant = slot_free & (credit_cnt < CREDIT_NUM) & |ent_txreq_vld.
//   Winner selection:
//     - Winner = first i with ent_txreq_vld[i], searching rr_ptr, rr_ptr+1, ..., wrapping mod ENTRY_NUM.
//     - Combinational, same cycle.
//   When can_grant (cycle N):
//     - ent_txreq_rdy[w] = ent_release_en[w] = 1 for exactly one w in cycle N; all other bits 0.
//     - rr_ptr <= (w == ENTRY_NUM-1) ? 0 : w+1.
//     - ds_req_vld <= 1, ds_req_pld <= pld[w], ds_req_entry_id <= w; visible in cycle N+1.
//     - Grant-to-output latency 1 cycle.
//   When not can_grant: rdy/release all 0; rr_ptr holds.
//   Output stage:
//     - ds_req_vld/pld/id hold stable while ds_req_vld & ~ds_req_rdy.
//     - On ds_req_rdy with no new grant: ds_req_vld <= 0.
//   Credit accounting:
//     - Credit is consumed at grant, not at downstream accept.
//     - Grant only: credit_cnt += 1.
//     - ds_fill_done only: credit_cnt -= 1.
//     - Both in the same cycle: credit_cnt unchanged.
//     - ds_fill_done with credit_cnt==0 and no grant: count stays 0; credit_err <= 1 (sticky until reset).
//     - credit_cnt == CREDIT_NUM: no grant, even if the slot is free.
//     - Returned credit is usable the cycle after ds_fill_done (credit_cnt is registered).
//   Entries may drop txreq_vld at any time; no grant is issued to an entry not valid in that cycle.
//   Payload of entry i is sampled only in its grant cycle.
//   Reset mid-operation clears the output stage and all credits; any in-flight downstream request is lost.
//   Upstream reset/flush is the system's responsibility.
// TESTING
//   1. Single entry 2 valid, ds_req_rdy=1 -> rdy/release=8'h04 for 1 cycle; next cycle ds_req_vld=1, entry_id=2; rr_ptr=3.
//   2. All 8 entries valid, requests held (not dropped) after grant, ds_req_rdy=1, a ds_fill_done pulse every cycle from the cycle after the first grant -> grants 0,1,2,...,7,0 in consecutive cycles; no bubbles; credit_cnt stays at 1.
//   3. CREDIT_NUM=4, no fill_done, 6 requesters -> exactly 4 grants; credit_cnt=4; stall; one fill_done -> 5th grant the cycle after.
//   4. ds_req_rdy=0 for 5 cycles with 2 requesters -> first payload held stable, no second grant; rdy=1 -> second granted same cycle as drain, next payload in the following cycle.
//   5. fill_done with credit_cnt=0 -> credit_cnt stays 0, credit_err=1 and remains set; grant + fill_done in the same cycle with cnt=2 -> cnt stays 2.
//   6. Assert rst_n low while ds_req_vld=1 and credit_cnt=3 -> all outputs 0 asynchronously; after release, first grant starts from entry 0.

Source files
------------

// File: rtl/icache_downstream_req_arb.sv
// Round-robin arbiter that moves MSHR refill requests onto the single downstream channel.
// Uses a one-deep registered output stage, and a credit counter caps the number of refills in flight.
module icache_downstream_req_arb #(
    parameter int unsigned ENTRY_NUM  = 8,
    parameter int unsigned PLD_W      = 42,
    parameter int unsigned CREDIT_NUM = 4,
    parameter int unsigned ID_W       = $clog2(ENTRY_NUM),
    localparam int unsigned CNT_W     = $clog2(CREDIT_NUM + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ENTRY_NUM-1:0]       ent_txreq_vld,
    input  logic [ENTRY_NUM*PLD_W-1:0] ent_txreq_pld,
    output logic [ENTRY_NUM-1:0]       ent_txreq_rdy,
    output logic [ENTRY_NUM-1:0]       ent_release_en,
    output logic                       ds_req_vld,
    input  logic                       ds_req_rdy,
    output logic [PLD_W-1:0]           ds_req_pld,
    output logic [ID_W-1:0]            ds_req_entry_id,
    input  logic                       ds_fill_done,
    output logic [CNT_W-1:0]           credit_cnt,
    output logic                       credit_err
);

    logic [ID_W-1:0]      r_rr_ptr,     w_rr_ptr_nxt;
    logic                 r_ds_vld,     w_ds_vld_nxt;
    logic [PLD_W-1:0]     r_ds_pld,     w_ds_pld_nxt;
    logic [ID_W-1:0]      r_ds_id,      w_ds_id_nxt;
    logic [CNT_W-1:0]     r_credit_cnt, w_credit_cnt_nxt;
    logic                 r_credit_err, w_credit_err_nxt;

    logic                 w_found;
    logic [ID_W-1:0]      w_win;
    logic [ID_W-1:0]      w_idx;
    logic [PLD_W-1:0]     w_win_pld;
    logic                 w_slot_free;
    logic                 w_can_grant;
    logic [ENTRY_NUM-1:0] w_grant_oh;

    // Search for the first valid entry, starting at rr_ptr and wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
            w_idx = ID_W'((32'(r_rr_ptr) + k) % ENTRY_NUM);
            if (!w_found && ent_txreq_vld[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Select the winner's payload with constant slices only.
    always_comb begin
        w_win_pld = '0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            if (w_win == ID_W'(i)) begin
                w_win_pld = ent_txreq_pld[i*PLD_W +: PLD_W];
            end
        end
    end

    // The grant is gated by rst_n so that the combinational grant outputs stay quiet during reset.
    assign w_slot_free = ~r_ds_vld | ds_req_rdy;
    assign w_can_grant = rst_n & w_slot_free & (r_credit_cnt < CNT_W'(CREDIT_NUM)) & w_found;
    assign w_grant_oh  = w_can_grant ? (ENTRY_NUM'(1) << w_win) : '0;

    assign ent_txreq_rdy   = w_grant_oh;
    assign ent_release_en  = w_grant_oh;
    assign ds_req_vld      = r_ds_vld;
    assign ds_req_pld      = r_ds_pld;
    assign ds_req_entry_id = r_ds_id;
    assign credit_cnt      = r_credit_cnt;
    assign credit_err      = r_credit_err;

    // Next state for the pointer, the output stage and the credits.
    always_comb begin
        w_rr_ptr_nxt     = r_rr_ptr;
        w_ds_vld_nxt     = r_ds_vld;
        w_ds_pld_nxt     = r_ds_pld;
        w_ds_id_nxt      = r_ds_id;
        w_credit_cnt_nxt = r_credit_cnt;
        w_credit_err_nxt = r_credit_err;

        if (w_can_grant) begin
            w_rr_ptr_nxt = (w_win == ID_W'(ENTRY_NUM - 1)) ? '0 : w_win + ID_W'(1);
            w_ds_vld_nxt = 1'b1;
            w_ds_pld_nxt = w_win_pld;
            w_ds_id_nxt  = w_win;
        end else if (ds_req_rdy) begin
            w_ds_vld_nxt = 1'b0;
        end

        case ({w_can_grant, ds_fill_done})
            2'b10: w_credit_cnt_nxt = r_credit_cnt + CNT_W'(1);
            2'b01: begin
                if (r_credit_cnt == '0) begin
                    w_credit_err_nxt = 1'b1;
                end else begin
                    w_credit_cnt_nxt = r_credit_cnt - CNT_W'(1);
                end
            end
            default: w_credit_cnt_nxt = r_credit_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_ds_vld     <= 1'b0;
            r_ds_pld     <= '0;
            r_ds_id      <= '0;
            r_credit_cnt <= '0;
            r_credit_err <= 1'b0;
        end else begin
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_ds_vld     <= w_ds_vld_nxt;
            r_ds_pld     <= w_ds_pld_nxt;
            r_ds_id      <= w_ds_id_nxt;
            r_credit_cnt <= w_credit_cnt_nxt;
            r_credit_err <= w_credit_err_nxt;
        end
    end

endmodule

// File: tb/tb_icache_downstream_req_arb.sv
// Scoreboard bench for icache_downstream_req_arb: a reference model queues expected downstream requests,
// and a monitor pops them when the downstream side accepts.
module tb_icache_downstream_req_arb;

    localparam int unsigned EN    = 8;
    localparam int unsigned PW    = 42;
    localparam int unsigned CR    = 4;
    localparam int unsigned IW    = 3;
    localparam int unsigned CW    = $clog2(CR + 1);

    typedef struct packed {
        logic [PW-1:0] pld;
        logic [IW-1:0] id;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [EN-1:0]     ent_txreq_vld;
    logic [EN*PW-1:0]  ent_txreq_pld;
    logic [EN-1:0]     ent_txreq_rdy;
    logic [EN-1:0]     ent_release_en;
    logic              ds_req_vld;
    logic              ds_req_rdy;
    logic [PW-1:0]     ds_req_pld;
    logic [IW-1:0]     ds_req_entry_id;
    logic              ds_fill_done;
    logic [CW-1:0]     credit_cnt;
    logic              credit_err;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Reference model state.
    int   m_rr   = 0;
    int   m_cnt  = 0;
    bit   m_err  = 0;
    bit   m_full = 0;

    icache_downstream_req_arb #(
        .ENTRY_NUM (EN),
        .PLD_W     (PW),
        .CREDIT_NUM(CR),
        .ID_W      (IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ent_txreq_vld  (ent_txreq_vld),
        .ent_txreq_pld  (ent_txreq_pld),
        .ent_txreq_rdy  (ent_txreq_rdy),
        .ent_release_en (ent_release_en),
        .ds_req_vld     (ds_req_vld),
        .ds_req_rdy     (ds_req_rdy),
        .ds_req_pld     (ds_req_pld),
        .ds_req_entry_id(ds_req_entry_id),
        .ds_fill_done   (ds_fill_done),
        .credit_cnt     (credit_cnt),
        .credit_err     (credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever the downstream side accepts at the coming edge.
    always @(negedge clk) begin
        if (rst_n && ds_req_vld && ds_req_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_req: actual id %0d with empty scoreboard, required none", ds_req_entry_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ds_req_pld", 64'(ds_req_pld), 64'(e.pld));
                chk("ds_req_entry_id", 64'(ds_req_entry_id), 64'(e.id));
            end
        end
    end

    // Drive one cycle of stimulus, check it against the model, then advance the model.
    task automatic step(input logic [EN-1:0] vld, input logic rdy, input logic fill);
        int w;
        logic [EN-1:0] exp_g;
        @(posedge clk);
        #2;
        ent_txreq_vld = vld;
        for (int i = 0; i < EN; i++) ent_txreq_pld[i*PW +: PW] = PW'({$urandom(), $urandom()});
        ds_req_rdy   = rdy;
        ds_fill_done = fill;
        #1;
        chk("ds_req_vld", 64'(ds_req_vld), 64'(m_full));
        chk("credit_cnt", 64'(credit_cnt), 64'(m_cnt));
        chk("credit_err", 64'(credit_err), 64'(m_err));
        w = -1;
        if ((!m_full || rdy) && m_cnt < CR && vld != '0) begin
            for (int k = 0; k < EN; k++) begin
                if (w < 0 && vld[(m_rr + k) % EN]) w = (m_rr + k) % EN;
            end
        end
        exp_g = (w >= 0) ? EN'(1 << w) : '0;
        chk("ent_txreq_rdy", 64'(ent_txreq_rdy), 64'(exp_g));
        chk("ent_release_en", 64'(ent_release_en), 64'(exp_g));
        if (w >= 0) begin
            exp_t e;
            e.pld = ent_txreq_pld[w*PW +: PW];
            e.id  = IW'(w);
            exp_q.push_back(e);
            m_rr   = (w + 1) % EN;
            m_full = 1;
        end else if (rdy) begin
            m_full = 0;
        end
        if (w >= 0 && !fill) m_cnt++;
        else if (w < 0 && fill) begin
            if (m_cnt == 0) m_err = 1;
            else m_cnt--;
        end
    endtask

    // Assert reset mid-cycle with requesters present; every output must drop at once.
    task automatic do_reset(input logic [EN-1:0] vld_hold);
        @(posedge clk);
        #2;
        ent_txreq_vld = vld_hold;
        ds_req_rdy    = 1'b1;
        ds_fill_done  = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rst_ds_req_vld", 64'(ds_req_vld), 64'(0));
        chk("rst_ds_req_pld", 64'(ds_req_pld), 64'(0));
        chk("rst_entry_id", 64'(ds_req_entry_id), 64'(0));
        chk("rst_credit_cnt", 64'(credit_cnt), 64'(0));
        chk("rst_credit_err", 64'(credit_err), 64'(0));
        chk("rst_txreq_rdy", 64'(ent_txreq_rdy), 64'(0));
        chk("rst_release_en", 64'(ent_release_en), 64'(0));
        m_rr = 0; m_cnt = 0; m_err = 0; m_full = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        ent_txreq_vld = '0;
        rst_n         = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ent_txreq_vld = '0;
        ent_txreq_pld = '0;
        ds_req_rdy    = 1'b0;
        ds_fill_done  = 1'b0;
        do_reset('0);

        // Single requester, then the next grant must start after it.
        step(8'h04, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h18, 1'b1, 1'b0);

        // All entries valid, fill every cycle: back-to-back rotation with steady credit.
        do_reset('0);
        step(8'hff, 1'b1, 1'b0);
        repeat (9) step(8'hff, 1'b1, 1'b1);

        // Credit exhaustion, then one fill releases a fifth grant on the following cycle.
        do_reset('0);
        repeat (6) step(8'h3f, 1'b1, 1'b0);
        step(8'h3f, 1'b1, 1'b1);
        step(8'h3f, 1'b1, 1'b0);
        step(8'h3f, 1'b1, 1'b0);

        // Downstream backpressure holds the output stage; the grant coincides with the drain.
        do_reset('0);
        step(8'h03, 1'b0, 1'b0);
        repeat (5) step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // A fill with no credit sets the sticky error; grant plus fill leaves the count unchanged.
        do_reset('0);
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);

        // Reset with a request pending and three credits used; arbitration restarts at entry 0.
        do_reset('0);
        repeat (3) step(8'h07, 1'b1, 1'b0);
        step(8'h07, 1'b0, 1'b0);
        do_reset(8'hff);
        step(8'hff, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b1);

        // Randomised traffic with varying backpressure and fill rates.
        do_reset('0);
        for (int c = 0; c < 2000; c++) begin
            logic [EN-1:0] v;
            v = EN'($urandom()) & EN'($urandom());
            step(v, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < ((c < 1000) ? 3 : 5)));
        end

        repeat (3) step(8'h00, 1'b1, 1'b0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
